// File: rtl/sipo_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_rx_pkg
//  Brief    : Shared constants, PID codes, FSM encoding and range macro for
//             the serial-in parallel-out receive block.
//  Revision : 1.0 - initial release
// ============================================================================
`ifndef SIPO_RX_PKG_SV
`define SIPO_RX_PKG_SV

// Width-to-range helper: `SIPO_RANGE(8) expands to 7:0
`define SIPO_RANGE(w) (w)-1:0

package sipo_rx_pkg;

    // SYNC as it appears in the shift register once fully received (LSB first)
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    // PID codes of interest on this datapath
    localparam logic [3:0] C_PID_ACK   = 4'b0010;
    localparam logic [3:0] C_PID_NAK   = 4'b1010;
    localparam logic [3:0] C_PID_IN    = 4'b1001;
    localparam logic [3:0] C_PID_DATA0 = 4'b0011;

    // Receive FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PID  = 2'd1,
        ST_DATA = 2'd2
    } sipo_state_t;

    // Upper nibble of a PID byte must be the complement of the lower nibble
    function automatic logic pid_check_ok(input logic [7:0] pid_byte);
        return (pid_byte[7:4] == ~pid_byte[3:0]);
    endfunction

endpackage

`endif
`default_nettype wire

// File: rtl/sipo_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_rx_if
//  Brief    : Serial input, receive-FIFO write port and packet status bundle
//             of the sipo_rx block.
//  Revision : 1.0 - initial release
// ============================================================================
interface sipo_rx_if #(
    parameter int SIPO_DATA_WIDTH = 8
);
    // serial bitstream
    logic                              sipo_data_in;
    logic                              sipo_data_val;
    logic                              sipo_data_last;
    // receive FIFO
    logic                              fifo_full;
    logic                              fifo_wr_en;
    logic [`SIPO_RANGE(SIPO_DATA_WIDTH)] fifo_wr_data;
    // packet status
    logic [3:0]                        pid_out;
    logic                              pid_valid;
    logic                              pid_err;
    logic                              packet_done;
    logic                              packet_err;
    logic                              rx_active;

    // Bitstream source / FIFO / transaction receiver side
    modport master (
        output sipo_data_in, sipo_data_val, sipo_data_last, fifo_full,
        input  fifo_wr_en, fifo_wr_data, pid_out, pid_valid, pid_err,
               packet_done, packet_err, rx_active
    );

    // Receiver side
    modport slave (
        input  sipo_data_in, sipo_data_val, sipo_data_last, fifo_full,
        output fifo_wr_en, fifo_wr_data, pid_out, pid_valid, pid_err,
               packet_done, packet_err, rx_active
    );
endinterface
`default_nettype wire

// File: rtl/sipo_rx_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_shifter
//  Brief    : LSB-first shift register and modulo-width bit counter. Exposes
//             the post-shift value and a strobe for the bit that completes a
//             word, both for the current strobe, so the owner can react on
//             the same clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module sipo_shifter #(
    parameter int SIPO_DATA_WIDTH = 8
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              i_bit,
    input  wire logic                              i_bit_val,
    input  wire logic                              i_cnt_clr,
    output logic [`SIPO_RANGE(SIPO_DATA_WIDTH)]    o_shift_next,
    output logic                                   o_byte_complete
);
    localparam int CNT_W = $clog2(SIPO_DATA_WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SIPO_DATA_WIDTH - 1);

    // Only the upper W-1 bits survive the next shift, so only they are stored
    logic [SIPO_DATA_WIDTH-2:0] r_hist;
    logic [CNT_W-1:0]           r_cnt;

    assign o_shift_next    = {i_bit, r_hist};
    assign o_byte_complete = i_bit_val && (r_cnt == C_CNT_LAST);

    // Shift a new bit in at the MSB on every strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
        end else if (i_bit_val) begin
            r_hist <= o_shift_next[SIPO_DATA_WIDTH-1:1];
        end
    end

    // Count strobed bits modulo the word width; clear wins over counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= '0;
        end else if (i_bit_val) begin
            r_cnt <= (r_cnt == C_CNT_LAST) ? '0 : r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_rx
//  Brief    : USB receive SIPO: SYNC hunt, PID capture/check, byte assembly
//             into the receive FIFO with a one-byte pending buffer, and
//             packet status pulses.
//  Macro    : SIPO_PID_CHECK_EN - enables the PID complement check; when
//             undefined every PID is accepted and pid_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int SIPO_DATA_WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    sipo_rx_if.slave  bus
);
    sipo_state_t r_state;
    sipo_state_t w_state_nxt;

    logic [`SIPO_RANGE(SIPO_DATA_WIDTH)] w_shift_next;
    logic                                w_byte_complete;
    logic                                w_bit_val;
    logic                                w_cnt_clr;
    logic                                w_new_byte;
    logic                                w_pid_ok;

    // next values of the registered outputs
    logic                                w_pid_valid_nxt;
    logic                                w_done_nxt;
    logic                                w_err_nxt;
    logic                                w_wr_en_nxt;
    logic [`SIPO_RANGE(SIPO_DATA_WIDTH)] w_wr_data_nxt;

    // pending buffer / overflow
    logic                                r_pend_vld;
    logic [`SIPO_RANGE(SIPO_DATA_WIDTH)] r_pend_data;
    logic                                w_pend_vld_nxt;
    logic [`SIPO_RANGE(SIPO_DATA_WIDTH)] w_pend_data_nxt;
    logic                                w_ovf_now;
    logic                                r_ovf;

    // registered outputs
    logic                                r_wr_en;
    logic [`SIPO_RANGE(SIPO_DATA_WIDTH)] r_wr_data;
    logic [3:0]                          r_pid_out;
    logic                                r_pid_valid;
    logic                                r_done;
    logic                                r_err;
    logic                                r_rx_active;

    assign w_bit_val = bus.sipo_data_val;

    sipo_shifter #(
        .SIPO_DATA_WIDTH (SIPO_DATA_WIDTH)
    ) u_shifter (
        .clk             (clk),
        .rst             (rst),
        .i_bit           (bus.sipo_data_in),
        .i_bit_val       (w_bit_val),
        .i_cnt_clr       (w_cnt_clr),
        .o_shift_next    (w_shift_next),
        .o_byte_complete (w_byte_complete)
    );

    // A payload byte is born only on the completing strobe while in DATA
    assign w_new_byte = (r_state == ST_DATA) && w_byte_complete;

`ifdef SIPO_PID_CHECK_EN
    logic w_pid_err_nxt;
    logic r_pid_err;

    assign w_pid_ok      = pid_check_ok(w_shift_next[7:0]);
    assign w_pid_err_nxt = (r_state == ST_PID) && w_byte_complete && !w_pid_ok;

    // PID check failure pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pid_err <= 1'b0;
        end else begin
            r_pid_err <= w_pid_err_nxt;
        end
    end

    assign bus.pid_err = r_pid_err;
`else
    assign w_pid_ok    = 1'b1;
    assign bus.pid_err = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and status decisions
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_clr       = 1'b0;
        w_pid_valid_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // last is meaningless outside a packet, only SYNC matters
                if (w_bit_val && (w_shift_next[7:0] == SYNC_PATTERN)) begin
                    w_state_nxt = ST_PID;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_PID: begin
                if (w_byte_complete) begin
                    if (!w_pid_ok) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_pid_valid_nxt = 1'b1;
                        if (bus.sipo_data_last) begin
                            // token/handshake: PID is the whole packet
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end
                end else if (w_bit_val && bus.sipo_data_last) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_bit_val && bus.sipo_data_last) begin
                    w_state_nxt = ST_IDLE;
                    // clean only if byte-aligned and nothing was dropped
                    if (w_byte_complete && !r_ovf && !w_ovf_now) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FIFO write selection: pending byte first, then new byte, else buffer/drop
    always_comb begin
        w_wr_en_nxt     = 1'b0;
        w_wr_data_nxt   = r_wr_data;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_data_nxt = r_pend_data;
        w_ovf_now       = 1'b0;
        if (!bus.fifo_full) begin
            if (r_pend_vld) begin
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = r_pend_data;
                if (w_new_byte) begin
                    w_pend_data_nxt = w_shift_next;
                end else begin
                    w_pend_vld_nxt = 1'b0;
                end
            end else if (w_new_byte) begin
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = w_shift_next;
            end
        end else if (w_new_byte) begin
            if (!r_pend_vld) begin
                w_pend_vld_nxt  = 1'b1;
                w_pend_data_nxt = w_shift_next;
            end else begin
                w_ovf_now = 1'b1;
            end
        end
    end

    // Pending buffer and per-packet overflow flag (new SYNC keeps pending)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_vld  <= 1'b0;
            r_pend_data <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_data <= w_pend_data_nxt;
            if (w_cnt_clr) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_now) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_pid_out   <= 4'h0;
            r_pid_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rx_active <= 1'b0;
        end else begin
            r_wr_en     <= w_wr_en_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_pid_valid <= w_pid_valid_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_rx_active <= (w_state_nxt != ST_IDLE);
            if (w_pid_valid_nxt) begin
                r_pid_out <= w_shift_next[3:0];
            end
        end
    end

    assign bus.fifo_wr_en   = r_wr_en;
    assign bus.fifo_wr_data = r_wr_data;
    assign bus.pid_out      = r_pid_out;
    assign bus.pid_valid    = r_pid_valid;
    assign bus.packet_done  = r_done;
    assign bus.packet_err   = r_err;
    assign bus.rx_active    = r_rx_active;
endmodule
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sipo_rx
//  Brief    : Scoreboard bench for sipo_rx: directed packets push expected
//             output events; a negedge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_rx;
    import sipo_rx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sipo_rx_if #(.SIPO_DATA_WIDTH(8)) bus ();

    sipo_rx #(.SIPO_DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       pv;
        logic [3:0] pid;
        logic       pe;
        logic       done;
        logic       err;
        int         cyc;   // -1: any cycle
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  last_cyc = 0;
    int  gap      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input logic wr, input logic [7:0] d, input logic pv,
                             input logic [3:0] pid, input logic pe,
                             input logic done, input logic err, input int c);
        ev_t e;
        e = '{wr, d, pv, pid, pe, done, err, c};
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: any output pulse must match the head of the expected queue
    always @(negedge clk) begin : mon
        ev_t got;
        ev_t want;
        if (bus.fifo_wr_en || bus.pid_valid || bus.pid_err || bus.packet_done || bus.packet_err) begin
            got = '{bus.fifo_wr_en, bus.fifo_wr_en ? bus.fifo_wr_data : 8'h00, bus.pid_valid,
                    bus.pid_valid ? bus.pid_out : 4'h0, bus.pid_err, bus.packet_done,
                    bus.packet_err, cyc};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d got wr=%0b data=%02h pv=%0b pid=%0h pe=%0b done=%0b err=%0b required none",
                         cyc, got.wr, got.data, got.pv, got.pid, got.pe, got.done, got.err);
            end else begin
                want = exp_q.pop_front();
                if (got.wr !== want.wr || got.data !== want.data || got.pv !== want.pv ||
                    got.pid !== want.pid || got.pe !== want.pe || got.done !== want.done ||
                    got.err !== want.err || (want.cyc >= 0 && want.cyc != cyc)) begin
                    n_fail++;
                    $display("FAIL event_compare cyc=%0d got wr=%0b data=%02h pv=%0b pid=%0h pe=%0b done=%0b err=%0b required wr=%0b data=%02h pv=%0b pid=%0h pe=%0b done=%0b err=%0b cyc=%0d",
                             cyc, got.wr, got.data, got.pv, got.pid, got.pe, got.done, got.err,
                             want.wr, want.data, want.pv, want.pid, want.pe, want.done, want.err, want.cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts and ends at posedge+1; last_cyc = monitor cycle of the response
    task automatic send_bit(input logic b, input logic l);
        idle(gap);
        bus.sipo_data_in   = b;
        bus.sipo_data_val  = 1'b1;
        bus.sipo_data_last = l;
        last_cyc = cyc + 1;
        @(posedge clk);
        #1;
        bus.sipo_data_in   = 1'b0;
        bus.sipo_data_val  = 1'b0;
        bus.sipo_data_last = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i], l && (i == 7));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"},       {31'd0, bus.fifo_wr_en},  32'd0);
        chk({tag, "_wr_data"},     {24'd0, bus.fifo_wr_data}, 32'd0);
        chk({tag, "_pid_out"},     {28'd0, bus.pid_out},     32'd0);
        chk({tag, "_pid_valid"},   {31'd0, bus.pid_valid},   32'd0);
        chk({tag, "_pid_err"},     {31'd0, bus.pid_err},     32'd0);
        chk({tag, "_packet_done"}, {31'd0, bus.packet_done}, 32'd0);
        chk({tag, "_packet_err"},  {31'd0, bus.packet_err},  32'd0);
        chk({tag, "_rx_active"},   {31'd0, bus.rx_active},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sipo_data_in   = 1'b0;
        bus.sipo_data_val  = 1'b0;
        bus.sipo_data_last = 1'b0;
        bus.fifo_full      = 1'b0;
        rst = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst = 1'b1;
        idle(2);

        // ACK handshake; a stray last in IDLE must be ignored
        send_bit(1'b0, 1'b1);
        send_byte(8'h80, 1'b0);
        chk("rx_active_after_sync", {31'd0, bus.rx_active}, 32'd1);
        send_byte(8'hD2, 1'b1);
        expect_ev(1'b0, 8'h00, 1'b1, C_PID_ACK, 1'b0, 1'b1, 1'b0, last_cyc);
        chk("rx_active_after_ack", {31'd0, bus.rx_active}, 32'd0);
        idle(3);
        chk("pid_out_held", {28'd0, bus.pid_out}, 32'h2);

        // DATA0 with two payload bytes, gaps between strobes
        gap = 1;
        send_byte(8'h80, 1'b0);
        send_byte(8'hC3, 1'b0);
        expect_ev(1'b0, 8'h00, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, last_cyc);
        send_byte(8'hA5, 1'b0);
        expect_ev(1'b1, 8'hA5, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, last_cyc);
        send_byte(8'h3C, 1'b1);
        expect_ev(1'b1, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, last_cyc);
        gap = 0;
        idle(3);

        // Malformed PID 0xD3
        send_byte(8'h80, 1'b0);
        send_byte(8'hD3, 1'b1);
`ifdef SIPO_PID_CHECK_EN
        expect_ev(1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, last_cyc);
`else
        expect_ev(1'b0, 8'h00, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, last_cyc);
`endif
        chk("rx_active_after_d3", {31'd0, bus.rx_active}, 32'd0);
        send_byte(8'hFF, 1'b0);
        idle(3);

        // Overflow: two bytes complete while FIFO full
        send_byte(8'h80, 1'b0);
        send_byte(8'hC3, 1'b0);
        expect_ev(1'b0, 8'h00, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, last_cyc);
        bus.fifo_full = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        idle(2);
        expect_ev(1'b1, 8'h11, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, cyc + 1);
        bus.fifo_full = 1'b0;
        idle(3);
        send_bit(1'b1, 1'b1);
        expect_ev(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, last_cyc);
        idle(3);

        // Truncated packet: 12 data bits, last on the 12th
        send_byte(8'h80, 1'b0);
        send_byte(8'hC3, 1'b0);
        expect_ev(1'b0, 8'h00, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, last_cyc);
        send_byte(8'h5A, 1'b0);
        expect_ev(1'b1, 8'h5A, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, last_cyc);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        expect_ev(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, last_cyc);
        idle(3);

        // Reset mid-DATA with a byte parked in the pending buffer
        gap = 2;
        send_byte(8'h80, 1'b0);
        send_byte(8'hC3, 1'b0);
        expect_ev(1'b0, 8'h00, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, last_cyc);
        bus.fifo_full = 1'b1;
        send_byte(8'h77, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("rx_active_before_reset", {31'd0, bus.rx_active}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        bus.fifo_full = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(3);
        gap = 0;
        send_byte(8'h80, 1'b0);
        send_byte(8'hD2, 1'b1);
        expect_ev(1'b0, 8'h00, 1'b1, C_PID_ACK, 1'b0, 1'b1, 1'b0, last_cyc);
        idle(5);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
